enigma_sym_rx: RTL and testbench

Receive-side back end of the Enigma cipher pipeline. Accepts coded letter indices (1..26) from the cipher core's output stream, which has no backpressure, and buffers them in a FIFO. It converts each index to uppercase ASCII and presents the result on a valid/ready byte stream toward a UART or host sink. Optionally inserts a space after every group of GROUP_LEN letters, giving the classic 5-letter telegraph format.

---
 rtl/enigma_sym_rx.sv | 157 +++++++++++++++
 tb/tb_enigma_sym_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_sym_rx.sv
// Receive back end of the Enigma pipeline: buffers letter indices, emits uppercase ASCII on a valid/ready stream.
// Optional telegraph grouping (a space after every GROUP_LEN letters) is built when GROUP_SPACE_EN is defined.
//
// state  | meaning
// IDLE   | output register empty, byte_val_o low
// LETTER | output register holds a letter, waiting for sink transfer
// SPACE  | output register holds the group separator 0x20 (GROUP_SPACE_EN only)
module enigma_sym_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int GROUP_LEN  = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic [6:0]                    sym_i,
    input  logic                          sym_val_i,
    output logic [7:0]                    byte_o,
    output logic                          byte_val_o,
    input  logic                          byte_rdy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
    output logic                          ovf_o,
    output logic                          err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

`ifdef GROUP_SPACE_EN
    typedef enum logic [1:0] {IDLE, LETTER, SPACE} state_t;
    localparam logic [3:0] GRP_LAST = 4'(GROUP_LEN - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       ld_space;
`else
    typedef enum logic [1:0] {IDLE, LETTER} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, lvl;
    logic [4:0]  rd_data;
    logic [7:0]  byte_q;
    logic        full, empty, sym_ok, sym_bad, wr_en, pop, xfer;

    assign lvl     = wr_ptr - rd_ptr;
    assign full    = (lvl == FULL_LVL);
    assign empty   = (lvl == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign sym_ok  = sym_val_i && (sym_i >= 7'd1) && (sym_i <= 7'd26);
    assign sym_bad = sym_val_i && !((sym_i >= 7'd1) && (sym_i <= 7'd26));
    // A full FIFO still accepts a write when the output side pops on the same edge.
    assign wr_en   = sym_ok && (!full || pop) && !clr_i;
    assign xfer    = (state_q != IDLE) && byte_rdy_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= sym_i[4:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
            err_o  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (sym_ok && full && !pop) ovf_o <= 1'b1;
            if (sym_bad) err_o <= 1'b1;
        end
    end

    // State register together with the output byte and group counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            byte_q  <= 8'h00;
`ifdef GROUP_SPACE_EN
            cnt_q   <= 4'd0;
`endif
        end else if (clr_i) begin
            state_q <= IDLE;
            byte_q  <= 8'h00;
`ifdef GROUP_SPACE_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef GROUP_SPACE_EN
            cnt_q   <= cnt_d;
            if (ld_space) byte_q <= 8'h20;
            else if (pop) byte_q <= 8'h40 + {3'b000, rd_data};
`else
            if (pop) byte_q <= 8'h40 + {3'b000, rd_data};
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
`ifdef GROUP_SPACE_EN
        cnt_d    = cnt_q;
        ld_space = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LETTER;
                end
            end
            LETTER: begin
                if (xfer) begin
`ifdef GROUP_SPACE_EN
                    if (cnt_q == GRP_LAST) begin
                        cnt_d    = 4'd0;
                        ld_space = 1'b1;
                        state_d  = SPACE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (!empty) pop = 1'b1;
                        else        state_d = IDLE;
                    end
`else
                    if (!empty) pop = 1'b1;
                    else        state_d = IDLE;
`endif
                end
            end
`ifdef GROUP_SPACE_EN
            SPACE: begin
                if (xfer) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LETTER;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_o     = byte_q;
        byte_val_o = (state_q != IDLE);
        fifo_lvl_o = lvl;
    end

endmodule

// File: tb/tb_enigma_sym_rx.sv
// Directed self-checking bench for enigma_sym_rx; expected byte streams honour GROUP_SPACE_EN
// the same way the design build does.
module tb_enigma_sym_rx;

    localparam int DEPTH = 16;
    localparam int GL    = 5;

    logic       clk_i = 1'b0;
    logic       rst_i, clr_i, sym_val_i, byte_rdy_i;
    logic [6:0] sym_i;
    logic [7:0] byte_o;
    logic       byte_val_o, ovf_o, err_o;
    logic [$clog2(DEPTH):0] fifo_lvl_o;

    int n_tests = 0;
    int n_fail  = 0;
    int grp     = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic       prev_clr   = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    enigma_sym_rx #(.FIFO_DEPTH(DEPTH), .GROUP_LEN(GL)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .sym_i      (sym_i),
        .sym_val_i  (sym_val_i),
        .byte_o     (byte_o),
        .byte_val_o (byte_val_o),
        .byte_rdy_i (byte_rdy_i),
        .fifo_lvl_o (fifo_lvl_o),
        .ovf_o      (ovf_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after posedge, so the negedge sees what the next edge will sample.
    always @(negedge clk_i) begin
        if (!rst_i && prev_stall && !prev_clr) begin
            chk("hold_val", byte_val_o, 1);
            chk("hold_byte", byte_o, prev_byte);
        end
        prev_stall = !rst_i && byte_val_o && !byte_rdy_i;
        prev_clr   = clr_i;
        prev_byte  = byte_o;
        if (!rst_i && !clr_i && byte_val_o && byte_rdy_i) got_q.push_back(byte_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int s);
        sym_i     = 7'(s);
        sym_val_i = 1'b1;
        tick();
        sym_val_i = 1'b0;
        sym_i     = 7'd0;
    endtask

    task automatic exp_letter(input int idx);
        exp_q.push_back(8'(idx + 64));
`ifdef GROUP_SPACE_EN
        grp++;
        if (grp == GL) begin
            exp_q.push_back(8'h20);
            grp = 0;
        end
`endif
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while ((byte_val_o || fifo_lvl_o != 0) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) chk({tag, "_timeout"}, 1, 0);
        compare_stream(tag);
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        grp   = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [3:0] pat;
        pat        = 4'b1001;
        rst_i      = 1'b1;
        clr_i      = 1'b0;
        sym_val_i  = 1'b0;
        sym_i      = 7'd0;
        byte_rdy_i = 1'b1;
        #12;
        chk("rst_byte", byte_o, 8'h00);
        chk("rst_val", byte_val_o, 0);
        chk("rst_lvl", fifo_lvl_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Latency and back-to-back throughput
        sym_i = 7'd1; sym_val_i = 1'b1;
        tick();
        chk("lat_val0", byte_val_o, 0);
        sym_i = 7'd2;
        tick();
        chk("lat_val1", byte_val_o, 1);
        chk("lat_a", byte_o, 8'h41);
        sym_i = 7'd3;
        tick();
        chk("b2b_val", byte_val_o, 1);
        chk("b2b_b", byte_o, 8'h42);
        sym_val_i = 1'b0; sym_i = 7'd0;
        tick();
        chk("b2b_val2", byte_val_o, 1);
        chk("b2b_c", byte_o, 8'h43);
        for (int i = 1; i <= 3; i++) exp_letter(i);
        drain("abc");
        do_clr();

        // Twelve Z letters: groups of five
        for (int i = 0; i < 12; i++) begin
            send(26);
            exp_letter(26);
        end
        drain("grp");
        chk("grp_idle", byte_val_o, 0);
        do_clr();

        // Stalled sink: capacity and overflow
        byte_rdy_i = 1'b0;
        for (int i = 1; i <= 18; i++) send(i);
        tick();
        chk("cap_lvl", fifo_lvl_o, DEPTH);
        chk("cap_ovf", ovf_o, 1);
        chk("cap_head", byte_o, 8'h41);
        for (int i = 1; i <= 17; i++) exp_letter(i);
        byte_rdy_i = 1'b1;
        drain("cap");
        chk("cap_ovf_sticky", ovf_o, 1);
        do_clr();
        chk("clr_ovf", ovf_o, 0);

        // Out-of-range symbols
        send(0);
        chk("err_set", err_o, 1);
        chk("err_lvl0", fifo_lvl_o, 0);
        send(27);
        chk("err_lvl27", fifo_lvl_o, 0);
        send(26);
        chk("err_lvl26", fifo_lvl_o, 1);
        exp_letter(26);
        drain("err");
        chk("err_sticky", err_o, 1);
        do_clr();
        chk("clr_err", err_o, 0);

        // Intermittent ready during a 4-letter burst
        for (int c = 0; c < 16; c++) begin
            byte_rdy_i = pat[c % 4];
            if (c < 4) begin
                sym_val_i = 1'b1;
                sym_i     = 7'(c + 5);
            end else begin
                sym_val_i = 1'b0;
                sym_i     = 7'd0;
            end
            tick();
        end
        byte_rdy_i = 1'b1;
        for (int i = 5; i <= 8; i++) exp_letter(i);
        drain("stall");
        do_clr();

        // Clear mid-stream, then a fresh group
        byte_rdy_i = 1'b0;
        for (int i = 1; i <= 6; i++) send(i);
        byte_rdy_i = 1'b1;
        tick(); tick(); tick();
        byte_rdy_i = 1'b0;
        for (int i = 1; i <= 3; i++) exp_letter(i);
        compare_stream("pre_clr");
        chk("pre_clr_lvl", fifo_lvl_o, 2);
        do_clr();
        chk("clr_val", byte_val_o, 0);
        chk("clr_lvl", fifo_lvl_o, 0);
        chk("clr_byte", byte_o, 8'h00);
        byte_rdy_i = 1'b1;
        for (int i = 7; i <= 11; i++) begin
            send(i);
            exp_letter(i);
        end
        drain("post_clr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
